// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer/flag controller for an async FIFO: synchronises the read
// Gray pointer into the write clock and produces wr_ptr, Gray wr_ptr, full/almost_full, level, overflow.
module async_fifo_wr_ctrl #(
  parameter int DEPTH              = 128,
  parameter int PTR_SIZE           = $clog2(DEPTH),
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_THRESH = DEPTH - 4
) (
  input  logic                i_wr_clk,
  input  logic                i_wr_reset_n,
  input  logic                i_wr_en,
  input  logic [PTR_SIZE:0]   i_rd_ptr_gray,
  output logic                o_wr_accept,
  output logic [PTR_SIZE:0]   o_wr_ptr,
  output logic [PTR_SIZE:0]   o_wr_ptr_gray,
  output logic                o_full,
  output logic                o_almost_full,
  output logic [PTR_SIZE:0]   o_wr_count,
  output logic                o_overflow
);

  localparam int                PW        = PTR_SIZE + 1;
  localparam logic [PTR_SIZE:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

  function automatic logic [PTR_SIZE:0] bin2gray(input logic [PTR_SIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_SIZE:0] gray2bin(input logic [PTR_SIZE:0] g);
    logic [PTR_SIZE:0] b;
    b[PTR_SIZE] = g[PTR_SIZE];
    for (int i = PTR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][PTR_SIZE:0] r_sync;
  logic [PTR_SIZE:0]                  r_wr_ptr;
  logic [PTR_SIZE:0]                  r_wr_ptr_gray;
  logic                               r_full;
  logic                               r_almost_full;
  logic [PTR_SIZE:0]                  r_wr_count;
  logic                               r_overflow;

  logic                               w_wr_accept;
  logic [PTR_SIZE:0]                  w_rq_gray;
  logic [PTR_SIZE:0]                  w_rq_bin;
  logic [PTR_SIZE:0]                  w_wr_ptr_next;
  logic [PTR_SIZE:0]                  w_full_pattern;
  logic                               w_full_next;
  logic [PTR_SIZE:0]                  w_wr_count_next;
  logic                               w_almost_full_next;

  // Plain flop chain: the port feeds stage 0 directly, no logic in between.
  always_ff @(posedge i_wr_clk) begin
    if (!i_wr_reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rd_ptr_gray};
    end
  end

  assign w_rq_gray = r_sync[SYNC_STAGES-1];
  assign w_rq_bin  = gray2bin(w_rq_gray);

  assign w_wr_accept   = i_wr_reset_n & i_wr_en & ~r_full;
  assign w_wr_ptr_next = r_wr_ptr + {{PTR_SIZE{1'b0}}, w_wr_accept};

  // Full when the write pointer is exactly one lap (DEPTH) ahead of the read pointer.
  assign w_full_pattern     = {~w_rq_gray[PTR_SIZE:PTR_SIZE-1], w_rq_gray[PTR_SIZE-2:0]};
  assign w_full_next        = (bin2gray(w_wr_ptr_next) == w_full_pattern);
  assign w_wr_count_next    = w_wr_ptr_next - w_rq_bin;
  assign w_almost_full_next = (w_wr_count_next >= AF_THRESH);

  always_ff @(posedge i_wr_clk) begin
    if (!i_wr_reset_n) begin
      r_wr_ptr      <= '0;
      r_wr_ptr_gray <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_wr_count    <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_next;
      r_wr_ptr_gray <= bin2gray(w_wr_ptr_next);
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_wr_count    <= w_wr_count_next;
      r_overflow    <= r_overflow | (i_wr_en & r_full);
    end
  end

  assign o_wr_accept   = w_wr_accept;
  assign o_wr_ptr      = r_wr_ptr;
  assign o_wr_ptr_gray = r_wr_ptr_gray;
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;
  assign o_wr_count    = r_wr_count;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Scoreboard bench for async_fifo_wr_ctrl (DEPTH=8): a driver pushes expected
// results from an occupancy-based model; a monitor pops and compares each cycle.
module tb_async_fifo_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int MODN  = 2 * DEPTH;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] rd_gray;
  logic       accept;
  logic [3:0] wr_ptr;
  logic [3:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_count;
  logic       overflow;

  async_fifo_wr_ctrl #(
    .DEPTH(DEPTH),
    .SYNC_STAGES(2),
    .ALMOST_FULL_THRESH(AFT)
  ) dut (
    .i_wr_clk(clk),
    .i_wr_reset_n(rst_n),
    .i_wr_en(wr_en),
    .i_rd_ptr_gray(rd_gray),
    .o_wr_accept(accept),
    .o_wr_ptr(wr_ptr),
    .o_wr_ptr_gray(wr_ptr_gray),
    .o_full(full),
    .o_almost_full(almost_full),
    .o_wr_count(wr_count),
    .o_overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit acc;
    int addr;
    int ptr;
    int gray;
    bit full;
    bit af;
    int cnt;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: accepted-write pointer, and the read pointer as seen
  // through a two-cycle crossing delay (older value in m_seen_old).
  int m_wr, m_seen_new, m_seen_old, m_cnt;
  bit m_full, m_af, m_ovf;
  int wr_total, rd_total;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % MODN;
  endfunction

  function automatic int from_gray(input int g);
    for (int b = 0; b < MODN; b++) begin
      if (to_gray(b) == g) return b;
    end
    return 0;
  endfunction

  function automatic void chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, want, $time);
    end
  endfunction

  task automatic step(input bit rst_v, input bit en_v, input int rd_g);
    exp_t e;
    bit   acc;
    @(negedge clk);
    rst_n   = rst_v;
    wr_en   = en_v;
    rd_gray = 4'(rd_g);
    e.addr  = m_wr;
    if (!rst_v) begin
      acc = 1'b0;
      m_wr = 0; m_seen_new = 0; m_seen_old = 0; m_cnt = 0;
      m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    end else begin
      acc = en_v && !m_full;
      if (en_v && m_full) m_ovf = 1'b1;
      if (acc) m_wr = (m_wr + 1) % MODN;
      m_cnt  = (m_wr - m_seen_old + MODN) % MODN;
      m_full = (m_cnt == DEPTH);
      m_af   = (m_cnt >= AFT);
      m_seen_old = m_seen_new;
      m_seen_new = from_gray(rd_g);
    end
    if (acc) wr_total++;
    e.acc  = acc;
    e.ptr  = m_wr;
    e.gray = to_gray(m_wr);
    e.full = m_full;
    e.af   = m_af;
    e.cnt  = m_cnt;
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  // Monitor: accept/address sampled mid-cycle, registered outputs 1 time unit after the edge.
  initial begin : monitor
    exp_t e;
    int   prev_gray;
    int   txn;
    bit   a_acc;
    int   a_addr;
    prev_gray = 0;
    txn = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        a_acc  = accept;
        a_addr = int'(wr_ptr);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("wr_accept", int'(a_acc), int'(e.acc));
        if (e.acc) begin
          chk("write_addr", a_addr, e.addr);
          chk("gray_one_bit_step", $countones(wr_ptr_gray ^ 4'(prev_gray)), 1);
        end
        chk("wr_ptr", int'(wr_ptr), e.ptr);
        chk("wr_ptr_gray", int'(wr_ptr_gray), e.gray);
        chk("full", int'(full), int'(e.full));
        chk("almost_full", int'(almost_full), int'(e.af));
        chk("wr_count", int'(wr_count), e.cnt);
        chk("overflow", int'(overflow), int'(e.ovf));
        prev_gray = int'(wr_ptr_gray);
        $display("txn %0d: acc=%0d ptr=%0d gray=%0d full=%0d af=%0d cnt=%0d ovf=%0d",
                 txn, a_acc, wr_ptr, wr_ptr_gray, full, almost_full, wr_count, overflow);
        txn++;
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; wr_en = 1'b0; rd_gray = 4'd0;
    wr_total = 0; rd_total = 0;
    m_wr = 0; m_seen_new = 0; m_seen_old = 0; m_cnt = 0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;

    // Reset held with write requests and a nonzero read pointer
    repeat (3) step(1'b0, 1'b1, 5);

    // Fill to full, then two rejected writes
    repeat (10) step(1'b1, 1'b1, 0);

    // Drain visibility: read pointer moves to 3, then one write
    repeat (3) step(1'b1, 1'b0, to_gray(3));
    step(1'b1, 1'b1, to_gray(3));
    step(1'b1, 1'b0, to_gray(3));

    // Full versus empty: wr_ptr=8 against rd=0 then rd=8
    step(1'b0, 1'b0, 0);
    repeat (8) step(1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 0);
    repeat (3) step(1'b1, 1'b0, to_gray(8));

    // Wrap-around with the reader trailing by two
    step(1'b0, 1'b0, 0);
    repeat (24) step(1'b1, 1'b1, to_gray((m_wr - 2 + MODN) % MODN));

    // Reset mid-operation after 5 writes and one overflow
    step(1'b0, 1'b0, 0);
    repeat (5) step(1'b1, 1'b1, 0);
    repeat (3) step(1'b1, 1'b0, to_gray(13));
    step(1'b1, 1'b1, to_gray(13));
    step(1'b0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b1, 0);

    // Randomised traffic with a reader that never passes the writer
    step(1'b0, 1'b0, 0);
    wr_total = 0;
    rd_total = 0;
    for (int i = 0; i < 400; i++) begin
      int room;
      room = wr_total - rd_total;
      if (room > 0) rd_total += $urandom_range(0, (room < 2) ? room : 2);
      step(1'b1, ($urandom_range(0, 3) != 0), to_gray(rd_total % MODN));
    end
    step(1'b1, 1'b0, to_gray(rd_total % MODN));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO storage array. Runs entirely on wr_clk. It synchronises the read domain's Gray-coded read pointer into wr_clk, generates the binary write pointer that addresses the array, and produces the Gray write pointer handed to the read domain. It also produces full, almost_full, fill level and a sticky overflow flag. It sits directly upstream of the storage array and drives its wr_ptr and full inputs.

Parameters:
DEPTH, 128, number of FIFO entries; must be a power of 2 and at least 4
PTR_SIZE, $clog2(DEPTH), address width; pointers are PTR_SIZE+1 bits (MSB is the wrap bit)
SYNC_STAGES, 2, flops in the rd_ptr_gray synchroniser; minimum 2
ALMOST_FULL_THRESH, DEPTH-4, wr_count value at or above which almost_full asserts

Ports:
wr_clk  input  1  write clock
wr_reset_n  input  1  synchronous active-low reset, sampled on rising wr_clk
wr_en  input  1  write request from producer
rd_ptr_gray  input  PTR_SIZE+1  Gray read pointer from read domain; asynchronous to wr_clk
wr_accept  output  1  combinational; wr_en accepted this cycle
wr_ptr  output  PTR_SIZE+1  binary write pointer; [PTR_SIZE-1:0] is the array address
wr_ptr_gray  output  PTR_SIZE+1  registered Gray write pointer to read domain
full  output  1  registered full flag
almost_full  output  1  registered; wr_count >= ALMOST_FULL_THRESH
wr_count  output  PTR_SIZE+1  registered fill level as seen by the write side, 0..DEPTH
overflow  output  1  sticky; write attempted while full

Behaviour:
- Reset (wr_reset_n=0 at a rising edge): all registers go to 0. This covers wr_ptr, wr_ptr_gray, full, almost_full, wr_count, overflow and every synchroniser stage. wr_accept is forced to 0 while wr_reset_n=0. Reset mid-operation discards all pointer state immediately; the read domain must be reset in the same window (system rule, not checked here).
- wr_accept = wr_reset_n & wr_en & ~full.
- Pointer update on accept: wr_ptr <= wr_ptr+1, modulo 2^(PTR_SIZE+1), wrapping from all-ones to 0. wr_ptr_gray <= bin2gray(wr_ptr+1), so wr_ptr_gray always equals bin2gray(wr_ptr). With no accept, both hold.
- Array contract: the array writes at the current wr_ptr on the same edge the pointer advances.
- Synchroniser: rd_ptr_gray is shifted through SYNC_STAGES flops. rq_gray is the last stage; rq_bin = gray2bin(rq_gray). No logic sits between the port and the first flop.
- Flag and count timing: full, wr_count and almost_full are computed from the post-update pointer (wr_ptr_next) and the current rq_bin/rq_gray, then registered.
  - full <= (bin2gray(wr_ptr_next) == {~rq_gray[PTR_SIZE:PTR_SIZE-1], rq_gray[PTR_SIZE-2:0]}).
  - wr_count <= wr_ptr_next - rq_bin, in PTR_SIZE+1-bit modular arithmetic.
  - almost_full <= (wr_count_next >= ALMOST_FULL_THRESH).
- Write-side latency: full asserts on the same edge that accepts the DEPTH-th outstanding write.
- Read-side latency: a change on rd_ptr_gray first affects full, wr_count and almost_full at the (SYNC_STAGES+1)-th rising edge after it. Flags are pessimistic: full may stay high while read frees are in flight, but must never be low with DEPTH entries outstanding.
- Overflow: wr_en=1 while full=1 drops the write (pointer unchanged) and sets overflow <= 1. overflow clears only on reset.
- Simultaneous full and read advance in one cycle: the write is rejected that cycle because full is registered. It is accepted on the first cycle after full deasserts.

Test Plan:
- Reset: DEPTH=8. Hold wr_reset_n=0 for 3 cycles with wr_en=1 and rd_ptr_gray=4'b0101 -> wr_accept=0; wr_ptr=0, wr_ptr_gray=0, full=0, wr_count=0, overflow=0 throughout.
- Fill and overflow: DEPTH=8, ALMOST_FULL_THRESH=6, rd_ptr_gray=0, wr_en=1 for 10 cycles ->
  - wr_accept high for 8 cycles;
  - almost_full=1 after the 6th accepting edge;
  - full=1 after the 8th accepting edge, with wr_ptr=4'b1000, wr_ptr_gray=4'b1100, wr_count=8;
  - cycles 9 and 10 rejected; overflow=1; wr_ptr stays 8.
- Drain visibility: from the full state, set rd_ptr_gray=4'b0010 (binary 3) -> full stays 1 for 2 edges; at the 3rd edge full=0, wr_count=5, almost_full=0. A write on the next cycle is accepted and gives wr_count=6, almost_full=1.
- Full versus empty ambiguity: DEPTH=8.
  - wr_ptr=8 with rd_ptr_gray=bin2gray(0)=4'b0000 -> full=1.
  - Then rd_ptr_gray=bin2gray(8)=4'b1100, settled -> full=0, wr_count=0.
- Wrap-around: DEPTH=8. Continuous writes with rd_ptr_gray driven as bin2gray(wr_ptr-2) -> wr_ptr goes 15 to 0. Each wr_ptr_gray step differs in exactly one bit, including 4'b1000 to 4'b0000. full never asserts and overflow stays 0.
- Reset mid-operation: after 5 accepted writes plus one overflow, apply wr_reset_n=0 for 1 cycle -> next edge shows wr_ptr=0, wr_count=0, full=0, overflow=0; the first write afterwards lands at address 0.
